mux_sel_sequencer: RTL and testbench
====================================

// Module: mux_sel_sequencer
// PURPOSE
//  Upstream source stage for the 4-bit 2:1 mux (mux2_1_4bit).
//  - Registers two channel data streams onto in1/in2.
//  - Generates sel, alternating between the channels with a programmable dwell time per channel.
//  - Replaces the hand-timed sel/in1/in2 stimulus with a deterministic clocked sequencer.
// PARAMETERS
//  WIDTH    4  data width of each channel and of in1/in2
//  DWELL_W  4  width of the dwell count inputs
// PORTS
//  clk         in   1        single clock; all logic on rising edge
//  rst         in   1        synchronous, active-high reset
//  en          in   1        run enable; low returns the FSM to IDLE
//  dwell0      in   DWELL_W  cycles to hold sel=0 (0 behaves as 1)
//  dwell1      in   DWELL_W  cycles to hold sel=1 (0 behaves as 1)
//  ch0_data    in   WIDTH    channel 0 sample
//  ch0_valid   in   1        ch0_data valid this cycle
//  ch1_data    in   WIDTH    channel 1 sample
//  ch1_valid   in   1        ch1_data valid this cycle
//  in1         out  WIDTH    registered ch0 data, to mux in1
//  in2         out  WIDTH    registered ch1 data, to mux in2
//  sel         out  1        registered mux select (0=in1, 1=in2)
//  sel_toggle  out  1        1-cycle pulse in the first cycle sel shows a new value
//  busy        out  1        high when the FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - in1=0, in2=0, sel=0, sel_toggle=0, busy=0.
//   - FSM=IDLE, cnt=0, pending flags=0.
//   - Takes effect mid-dwell with no partial completion.
//  Data capture:
//   - in1<=ch0_data when ch0_valid; in2<=ch1_data when ch1_valid; otherwise hold.
//   - Capture is independent of FSM state, including IDLE.
//   - Latency is 1 cycle.
//  FSM states: IDLE, CH0 (sel=0), CH1 (sel=1). Entering CH0 or CH1 loads cnt=max(dwellX,1)-1.
//   - IDLE -> CH0 when en=1.
//   - CHx -> CH(other) when cnt==0, else cnt<=cnt-1. One dwell is max(dwellX,1) cycles.
//   - Any state -> IDLE when en=0, with sel=0 the next cycle. The en=0 check has priority over a dwell expiry in the same cycle.
//  Dwell sampling:
//   - dwell0/dwell1 are sampled only on state entry.
//   - Changes mid-dwell take effect at the next entry.
//  sel_toggle:
//   - Asserted in the first cycle of CH1 entry and CH0 re-entry.
//   - Not asserted on IDLE->CH0, because sel is already 0.
//   - Asserted on CH1->IDLE, because sel falls.
//  busy=1 in CH0 and CH1.
//  Counter arithmetic is unsigned DWELL_W bits and never wraps: decrement only when cnt!=0.
// CONFIGURATION
//  SKIP_INVALID_EN defined:
//   - Sticky pending0/pending1 are set by chX_valid and cleared on entering CHx.
//   - At dwell expiry, switch only if the other channel's pending flag is set (or its valid is high that cycle).
//   - Otherwise stay in the current state, reload its dwell, and do not pulse sel_toggle.
//  SKIP_INVALID_EN undefined: no pending flags; strict alternation regardless of valid.
// STRUCTURE
//  Package mux_seq_pkg:
//   - state_t enum {IDLE, CH0, CH1} (2 bits).
//   - Localparam defaults WIDTH=4, DWELL_W=4.
//  Sub-module dwell_counter(DWELL_W):
//   - Inputs: load, load_val.
//   - Output: expire (cnt==0). Saturating decrement.
//   - Instantiated once and shared by both channels.
//  Data registers and FSM stay in the top module.
// TESTING
//  Bench instantiates mux_sel_sequencer driving mux2_1_4bit and checks out_mux2_1 against the model.
//  1 Reset: rst=1 for 2 cycles, then dwell0=3, dwell1=2, en=1 -> sel pattern 0,0,0,1,1,0,0,0,...; sel_toggle pulses on each change.
//  2 Dwell zero: dwell0=0, dwell1=0 -> sel toggles every cycle; sel_toggle high every cycle.
//  3 Capture: ch0_valid=1 with 4'hA, ch1_valid=1 with 4'h5 -> next cycle in1=A, in2=5. While sel=1, out_mux2_1=5.
//  4 Disable: en->0 mid CH1 with cnt=2 -> next cycle sel=0, busy=0, sel_toggle=1. en->1 -> restart in CH0 with full dwell0.
//  5 Reset mid-dwell: rst pulse during CH1 -> all outputs 0 next cycle; data is not re-captured until valid returns.
//  6 SKIP_INVALID_EN: ch1_valid never asserted, dwell0=2 -> sel stays 0 and sel_toggle stays 0. Single ch1_valid pulse -> one CH1 dwell, then back to CH0.

Source files
------------

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and default widths for the mux select sequencer.
// Build option: SKIP_INVALID_EN enables valid-gated channel switching.
package mux_seq_pkg;

  localparam int WIDTH   = 4;
  localparam int DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Bundle between the sequencer and its driver/consumer.
// master drives control and channel data; slave is the sequencer.
interface mux_sel_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
);

  logic               en;
  logic [DWELL_W-1:0] dwell0;
  logic [DWELL_W-1:0] dwell1;
  logic [WIDTH-1:0]   ch0_data;
  logic               ch0_valid;
  logic [WIDTH-1:0]   ch1_data;
  logic               ch1_valid;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               sel;
  logic               sel_toggle;
  logic               busy;

  modport master (
    output en, dwell0, dwell1,
    output ch0_data, ch0_valid,
    output ch1_data, ch1_valid,
    input  in1, in2, sel,
    input  sel_toggle, busy
  );

  modport slave (
    input  en, dwell0, dwell1,
    input  ch0_data, ch0_valid,
    input  ch1_data, ch1_valid,
    output in1, in2, sel,
    output sel_toggle, busy
  );

endinterface

// File: rtl/mux_sel_sequencer_dwell_counter.sv
// Shared dwell down-counter: load wins, otherwise saturating decrement.
// Build option: SKIP_INVALID_EN (not used here).
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Clocked source for the 4-bit 2:1 mux: registered in1/in2 and dwell-timed sel.
// Build option: SKIP_INVALID_EN switches channels only when the other has data.
module mux_sel_sequencer #(
  parameter int WIDTH   = mux_seq_pkg::WIDTH,
  parameter int DWELL_W = mux_seq_pkg::DWELL_W
) (
  input logic             clk,
  input logic             rst,
  mux_sel_sequencer_if.slave bus
);
  import mux_seq_pkg::*;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   in1_q, in2_q;
  logic               sel_q, tog_q, busy_q;
  logic               sel_d;
  logic               load;
  logic [DWELL_W-1:0] load_val;
  logic               expire;
  logic               go0, go1;

  function automatic logic [DWELL_W-1:0] ld(
    input logic [DWELL_W-1:0] d
  );
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

`ifdef SKIP_INVALID_EN
  logic pend0_q, pend1_q;
  logic pend0_d, pend1_d;
  logic enter0, enter1;

  assign go0    = pend0_q | bus.ch0_valid;
  assign go1    = pend1_q | bus.ch1_valid;
  assign enter0 = (state_d == CH0) && (state_q != CH0);
  assign enter1 = (state_d == CH1) && (state_q != CH1);
  assign pend0_d = (pend0_q | bus.ch0_valid) & ~enter0;
  assign pend1_d = (pend1_q | bus.ch1_valid) & ~enter1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
    end else begin
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
    end
  end
`else
  assign go0 = 1'b1;
  assign go1 = 1'b1;
`endif

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .expire_o   (expire)
  );

  // en=0 overrides any dwell expiry in the same cycle
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = CH0;
          load     = 1'b1;
          load_val = ld(bus.dwell0);
        end
        CH0: if (expire) begin
          load = 1'b1;
          if (go1) begin
            state_d  = CH1;
            load_val = ld(bus.dwell1);
          end else begin
            load_val = ld(bus.dwell0);
          end
        end
        CH1: if (expire) begin
          load = 1'b1;
          if (go0) begin
            state_d  = CH0;
            load_val = ld(bus.dwell0);
          end else begin
            load_val = ld(bus.dwell1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sel_d = (state_d == CH1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      sel_q   <= 1'b0;
      tog_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.ch0_valid) in1_q <= bus.ch0_data;
      if (bus.ch1_valid) in2_q <= bus.ch1_data;
      sel_q   <= sel_d;
      tog_q   <= sel_d ^ sel_q;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.in1        = in1_q;
  assign bus.in2        = in2_q;
  assign bus.sel        = sel_q;
  assign bus.sel_toggle = tog_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer feeding a 2:1 mux.
// Build option: SKIP_INVALID_EN selects the valid-gated scenario.
module tb_mux_sel_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.WIDTH(4), .DWELL_W(4)) bus ();

  mux_sel_sequencer #(
    .WIDTH   (4),
    .DWELL_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // downstream 2:1 mux
  logic [3:0] out_mux2_1;
  assign out_mux2_1 = bus.sel ? bus.in2 : bus.in1;

  typedef struct {
    string      nm;
    logic       s;
    logic       t;
    logic       b;
    logic [3:0] i1;
    logic [3:0] i2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] m;
      e = sb.pop_front();
      m = e.s ? e.i2 : e.i1;
      chk({e.nm, ".sel"},  {3'b0, bus.sel},        {3'b0, e.s});
      chk({e.nm, ".tog"},  {3'b0, bus.sel_toggle}, {3'b0, e.t});
      chk({e.nm, ".busy"}, {3'b0, bus.busy},       {3'b0, e.b});
      chk({e.nm, ".in1"},  bus.in1, e.i1);
      chk({e.nm, ".in2"},  bus.in2, e.i2);
      chk({e.nm, ".mux"},  out_mux2_1, m);
    end
  end

  task automatic cyc(input string nm, input logic s, input logic t,
                     input logic b, input logic [3:0] i1,
                     input logic [3:0] i2);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm = nm;
    e.s  = s;
    e.t  = t;
    e.b  = b;
    e.i1 = i1;
    e.i2 = i2;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.dwell0    = 4'd0;
    bus.dwell1    = 4'd0;
    bus.ch0_data  = 4'h0;
    bus.ch0_valid = 1'b0;
    bus.ch1_data  = 4'h0;
    bus.ch1_valid = 1'b0;

    cyc("rst0", 0, 0, 0, 4'h0, 4'h0);
    cyc("rst1", 0, 0, 0, 4'h0, 4'h0);

`ifdef SKIP_INVALID_EN
    rst           = 1'b0;
    bus.dwell0    = 4'd2;
    bus.dwell1    = 4'd2;
    bus.en        = 1'b1;
    bus.ch0_data  = 4'h2;
    bus.ch0_valid = 1'b1;
    cyc("sk_e1", 0, 0, 1, 4'h2, 4'h0);
    cyc("sk_e2", 0, 0, 1, 4'h2, 4'h0);
    cyc("sk_e3", 0, 0, 1, 4'h2, 4'h0);
    cyc("sk_e4", 0, 0, 1, 4'h2, 4'h0);
    cyc("sk_e5", 0, 0, 1, 4'h2, 4'h0);
    bus.ch1_data  = 4'h9;
    bus.ch1_valid = 1'b1;
    cyc("sk_e6", 0, 0, 1, 4'h2, 4'h9);
    bus.ch1_valid = 1'b0;
    cyc("sk_e7", 1, 1, 1, 4'h2, 4'h9);
    cyc("sk_e8", 1, 0, 1, 4'h2, 4'h9);
    cyc("sk_e9", 0, 1, 1, 4'h2, 4'h9);
    cyc("sk_e10", 0, 0, 1, 4'h2, 4'h9);
    cyc("sk_e11", 0, 0, 1, 4'h2, 4'h9);
    cyc("sk_e12", 0, 0, 1, 4'h2, 4'h9);
`else
    // basic alternation, dwell 3/2
    rst        = 1'b0;
    bus.dwell0 = 4'd3;
    bus.dwell1 = 4'd2;
    bus.en     = 1'b1;
    cyc("t1_e1", 0, 0, 1, 4'h0, 4'h0);
    cyc("t1_e2", 0, 0, 1, 4'h0, 4'h0);
    cyc("t1_e3", 0, 0, 1, 4'h0, 4'h0);
    cyc("t1_e4", 1, 1, 1, 4'h0, 4'h0);
    cyc("t1_e5", 1, 0, 1, 4'h0, 4'h0);
    cyc("t1_e6", 0, 1, 1, 4'h0, 4'h0);
    cyc("t1_e7", 0, 0, 1, 4'h0, 4'h0);
    cyc("t1_e8", 0, 0, 1, 4'h0, 4'h0);
    cyc("t1_e9", 1, 1, 1, 4'h0, 4'h0);

    // zero dwell toggles every cycle
    bus.dwell0 = 4'd0;
    bus.dwell1 = 4'd0;
    cyc("t2_e10", 1, 0, 1, 4'h0, 4'h0);
    cyc("t2_e11", 0, 1, 1, 4'h0, 4'h0);
    cyc("t2_e12", 1, 1, 1, 4'h0, 4'h0);
    cyc("t2_e13", 0, 1, 1, 4'h0, 4'h0);
    cyc("t2_e14", 1, 1, 1, 4'h0, 4'h0);

    // capture then hold
    bus.ch0_data  = 4'hA;
    bus.ch0_valid = 1'b1;
    bus.ch1_data  = 4'h5;
    bus.ch1_valid = 1'b1;
    cyc("t3_e15", 0, 1, 1, 4'hA, 4'h5);
    bus.ch0_valid = 1'b0;
    bus.ch1_valid = 1'b0;
    bus.ch0_data  = 4'h3;
    bus.ch1_data  = 4'hC;
    cyc("t3_e16", 1, 1, 1, 4'hA, 4'h5);
    bus.dwell0 = 4'd3;
    bus.dwell1 = 4'd3;
    cyc("t3_e17", 0, 1, 1, 4'hA, 4'h5);
    cyc("t3_e18", 0, 0, 1, 4'hA, 4'h5);
    cyc("t3_e19", 0, 0, 1, 4'hA, 4'h5);
    cyc("t3_e20", 1, 1, 1, 4'hA, 4'h5);

    // disable mid CH1 (cnt=2), then restart
    bus.en = 1'b0;
    cyc("t4_e21", 0, 1, 0, 4'hA, 4'h5);
    bus.en = 1'b1;
    cyc("t4_e22", 0, 0, 1, 4'hA, 4'h5);
    cyc("t4_e23", 0, 0, 1, 4'hA, 4'h5);
    cyc("t4_e24", 0, 0, 1, 4'hA, 4'h5);
    cyc("t4_e25", 1, 1, 1, 4'hA, 4'h5);
    cyc("t4_e26", 1, 0, 1, 4'hA, 4'h5);

    // reset mid-dwell, capture only on new valid
    rst = 1'b1;
    cyc("t5_e27", 0, 0, 0, 4'h0, 4'h0);
    rst    = 1'b0;
    bus.en = 1'b0;
    cyc("t5_e28", 0, 0, 0, 4'h0, 4'h0);
    bus.ch0_data  = 4'h7;
    bus.ch0_valid = 1'b1;
    cyc("t5_e29", 0, 0, 0, 4'h7, 4'h0);
    bus.ch0_valid = 1'b0;
    cyc("t5_e30", 0, 0, 0, 4'h7, 4'h0);
`endif

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
